// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - heading codes and direction helpers for the two-player step controller
package snake_pkg;

    typedef logic [4:0] dir_t;

    localparam dir_t DIR_START = 5'b00000;
    localparam dir_t DIR_UP    = 5'b00010;
    localparam dir_t DIR_LEFT  = 5'b00100;
    localparam dir_t DIR_DOWN  = 5'b01000;
    localparam dir_t DIR_RIGHT = 5'b10000;
    localparam dir_t DIR_RESET = 5'b11111;

    // Non-direction codes map to START so they can never match a real heading.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:    opposite = DIR_DOWN;
            DIR_DOWN:  opposite = DIR_UP;
            DIR_LEFT:  opposite = DIR_RIGHT;
            DIR_RIGHT: opposite = DIR_LEFT;
            default:   opposite = DIR_START;
        endcase
    endfunction

    function automatic logic is_dir(input dir_t d);
        is_dir = (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
    endfunction

endpackage

// File: rtl/snake_step_ctrl_dir_lane.sv
// rtl/snake_step_ctrl_dir_lane.sv - per-player pending request and heading update
module dir_lane
    import snake_pkg::*;
#(
    parameter dir_t INIT_DIR = DIR_UP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] dir_in,
    input  logic       step,
    input  logic       hold_reset,
    output logic [4:0] state
);

    dir_t state_q, state_d;
    dir_t pend_q, pend_d;
    logic pend_valid_q, pend_valid_d;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        if (hold_reset) begin
            state_d      = DIR_RESET;
            pend_valid_d = 1'b0;
        end else begin
            if (step) begin
                if (state_q == DIR_RESET) begin
                    state_d = INIT_DIR;
                end else if (pend_valid_q && (pend_q != opposite(state_q))) begin
                    state_d = pend_q;
                end
                pend_valid_d = 1'b0;
            end
            // A request seen in the step cycle survives the clear and waits for the next step.
            if (is_dir(dir_in)) begin
                pend_d       = dir_in;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DIR_START;
            pend_q       <= DIR_START;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/snake_step_ctrl.sv
// rtl/snake_step_ctrl.sv - game step timer, RESET detection and two heading lanes
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] p1_dir,
    input  logic [4:0] p2_dir,
    input  logic       pause,
    output logic [4:0] p1_state,
    output logic [4:0] p2_state,
    output logic       step
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_reset;
    logic             step_int;

    assign hold_reset = (p1_dir == DIR_RESET) || (p2_dir == DIR_RESET);
    assign step_int   = !pause && !hold_reset && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (hold_reset) begin
            cnt_d = '0;
        end else if (!pause) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    dir_lane #(.INIT_DIR(DIR_UP)) u_p1_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .dir_in     (p1_dir),
        .step       (step_int),
        .hold_reset (hold_reset),
        .state      (p1_state)
    );

    dir_lane #(.INIT_DIR(DIR_DOWN)) u_p2_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .dir_in     (p2_dir),
        .step       (step_int),
        .hold_reset (hold_reset),
        .state      (p2_state)
    );

    assign step = step_int;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb/tb_snake_step_ctrl.sv - directed table-driven bench for snake_step_ctrl with TICK_DIV=4
module tb_snake_step_ctrl;

    localparam logic [4:0] S = 5'b00000;
    localparam logic [4:0] U = 5'b00010;
    localparam logic [4:0] L = 5'b00100;
    localparam logic [4:0] D = 5'b01000;
    localparam logic [4:0] R = 5'b10000;
    localparam logic [4:0] X = 5'b11111;

    typedef struct {
        logic [4:0] p1;
        logic [4:0] p2;
        logic       pause;
        logic       exp_step;
        logic [4:0] exp_p1;
        logic [4:0] exp_p2;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] p1_dir = 5'b0;
    logic [4:0] p2_dir = 5'b0;
    logic       pause = 1'b0;
    logic [4:0] p1_state;
    logic [4:0] p2_state;
    logic       step;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    snake_step_ctrl #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p1_dir   (p1_dir),
        .p2_dir   (p2_dir),
        .pause    (pause),
        .p1_state (p1_state),
        .p2_state (p2_state),
        .step     (step)
    );

    task automatic add(input int n, input logic [4:0] a, input logic [4:0] b, input logic pz,
                       input logic es, input logic [4:0] e1, input logic [4:0] e2);
        vec_t v;
        v.p1 = a; v.p2 = b; v.pause = pz; v.exp_step = es; v.exp_p1 = e1; v.exp_p2 = e2;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic es, input logic [4:0] e1, input logic [4:0] e2);
        n_tests++;
        if (step !== es || p1_state !== e1 || p2_state !== e2) begin
            n_fail++;
            $display("FAIL %s: got step=%b p1=%b p2=%b, want step=%b p1=%b p2=%b",
                     name, step, p1_state, p2_state, es, e1, e2);
        end
    endtask

    initial begin
        int found;
        // idle stepping from START
        add(3, S, S, 0, 0, S, S); add(1, S, S, 0, 1, S, S);
        add(3, S, S, 0, 0, S, S); add(1, S, S, 0, 1, S, S);
        // latest pending wins
        add(1, R, S, 0, 0, S, S); add(1, U, S, 0, 0, S, S);
        add(1, S, S, 0, 0, S, S); add(1, S, S, 0, 1, S, S);
        // blocked reversal, then idle step
        add(1, D, S, 0, 0, U, S); add(2, S, S, 0, 0, U, S); add(1, S, S, 0, 1, U, S);
        add(3, S, S, 0, 0, U, S); add(1, S, S, 0, 1, U, S);
        // request only in the step cycle is deferred
        add(3, S, S, 0, 0, U, S); add(1, S, L, 0, 1, U, S);
        add(3, S, S, 0, 0, U, S); add(1, S, S, 0, 1, U, S);
        // independent lanes: p1 turns, p2 reversal blocked
        add(1, L, R, 0, 0, U, L); add(2, S, S, 0, 0, U, L); add(1, S, S, 0, 1, U, L);
        // pause holds the counter at 1 for 10 cycles
        add(1, S, S, 0, 0, L, L); add(10, S, S, 1, 0, L, L);
        add(2, S, S, 0, 0, L, L); add(1, S, S, 0, 1, L, L);
        add(3, S, S, 0, 0, L, L); add(1, S, S, 1, 0, L, L); add(1, S, S, 0, 1, L, L);
        // RESET in a step cycle, held two cycles, window requests ignored
        add(1, S, S, 0, 0, L, L); add(1, U, S, 0, 0, L, L); add(1, S, S, 0, 0, L, L);
        add(1, S, X, 0, 0, L, L); add(1, S, X, 0, 0, X, X); add(1, S, S, 0, 0, X, X);
        add(1, R, L, 0, 0, X, X); add(1, S, S, 0, 0, X, X); add(1, S, S, 0, 1, X, X);
        add(3, S, S, 0, 0, U, D); add(1, S, S, 0, 1, U, D); add(1, S, S, 0, 0, U, D);

        #2;
        check("async_reset_state", 1'b0, S, S);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        foreach (vecs[i]) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            p1_dir = vecs[i].p1; p2_dir = vecs[i].p2; pause = vecs[i].pause;
            #1;
            check($sformatf("row%0d", i), vecs[i].exp_step, vecs[i].exp_p1, vecs[i].exp_p2);
        end

        // reset asserted mid-period, away from any clock edge
        repeat (2) begin
            @(posedge clk);
            #1 p1_dir = S; p2_dir = S; pause = 1'b0;
        end
        #3 rst_n = 1'b0;
        #1 check("midperiod_reset", 1'b0, S, S);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("post_release", 1'b0, S, S);
        found = -1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #2;
            end
            if (step === 1'b1 && found < 0) found = k;
        end
        n_tests++;
        if (found != 3) begin
            n_fail++;
            $display("FAIL first_step_after_reset: got cycle %0d, want cycle 3", found);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
